// File: rtl/mul_pipe_hs.sv
// mul_pipe_hs: parametrised pipelined multiplier with valid/ready handshake.
// Each register stage folds a P-bit slice of the multiplier into a 2*WIDTH-bit
// running sum. Operands, mode and valid travel with the sum. A stall freezes
// every stage, bubbles included, so the output holds while the consumer waits.
module mul_pipe_hs #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     mul_a,
  input  logic [WIDTH-1:0]     mul_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   mul_out,
  output logic                 busy
);

  localparam int P  = WIDTH / STAGES;
  localparam int PW = 2 * WIDTH;

  // Add the partial products for multiplier bits [k*P .. k*P+P-1] to sum_in.
  // In signed mode the multiplier MSB carries negative weight, so its partial
  // product is subtracted; the sign-extended multiplicand does the rest.
  function automatic logic signed [PW-1:0] f_acc_slice(
    input logic signed [PW-1:0] a_ext,
    input logic [WIDTH-1:0]     b,
    input logic                 sgn,
    input logic signed [PW-1:0] sum_in,
    input int                   k
  );
    logic signed [PW-1:0] acc;
    logic [WIDTH-1:0]     bs;
    int                   idx;
    acc = sum_in;
    bs  = b >> (k * P);
    for (int j = 0; j < P; j++) begin
      idx = k * P + j;
      if (bs[0]) begin
        if (sgn && (idx == WIDTH - 1)) begin
          acc = acc - (a_ext << idx);
        end else begin
          acc = acc + (a_ext << idx);
        end
      end
      bs = bs >> 1;
    end
    return acc;
  endfunction

  logic                 w_stall;
  logic                 w_vld_in  [STAGES];
  logic signed [PW-1:0] w_a_in    [STAGES];
  logic [WIDTH-1:0]     w_b_in    [STAGES];
  logic                 w_sgn_in  [STAGES];
  logic signed [PW-1:0] w_sum_in  [STAGES];
  logic                 w_vld_out [STAGES];
  logic signed [PW-1:0] w_sum_out [STAGES];

  // A held, un-taken result freezes the whole pipe.
  assign w_stall  = w_vld_out[STAGES-1] & ~out_ready;
  assign in_ready = ~w_stall;

  // Stage 0 inputs come straight from the ports; the multiplicand is widened
  // once here according to the mode sampled with it.
  assign w_vld_in[0] = in_valid;
  assign w_a_in[0]   = {{WIDTH{in_signed & mul_a[WIDTH-1]}}, mul_a};
  assign w_b_in[0]   = mul_b;
  assign w_sgn_in[0] = in_signed;
  assign w_sum_in[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic signed [PW-1:0] w_sum_nxt;
    logic                 r_vld_p;
    logic signed [PW-1:0] r_sum_p;

    assign w_sum_nxt    = f_acc_slice(w_a_in[k], w_b_in[k], w_sgn_in[k], w_sum_in[k], k);
    assign w_vld_out[k] = r_vld_p;
    assign w_sum_out[k] = r_sum_p;

    // Stage valid bit: cleared by reset, advances only when not stalled.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld_p <= 1'b0;
      end else if (!w_stall) begin
        r_vld_p <= w_vld_in[k];
      end
    end

    if (k == STAGES - 1) begin : g_last
      // Output register: cleared by reset, loads only real results so the
      // last product stays visible after the pipe empties.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sum_p <= '0;
        end else if (!w_stall && w_vld_in[k]) begin
          r_sum_p <= w_sum_nxt;
        end
      end
    end else begin : g_mid
      logic signed [PW-1:0] r_a_p;
      logic [WIDTH-1:0]     r_b_p;
      logic                 r_sgn_p;

      // Intermediate datapath register: loads only when a valid op moves in.
      always_ff @(posedge clk) begin
        if (!w_stall && w_vld_in[k]) begin
          r_sum_p <= w_sum_nxt;
          r_a_p   <= w_a_in[k];
          r_b_p   <= w_b_in[k];
          r_sgn_p <= w_sgn_in[k];
        end
      end

      assign w_vld_in[k+1] = r_vld_p;
      assign w_sum_in[k+1] = r_sum_p;
      assign w_a_in[k+1]   = r_a_p;
      assign w_b_in[k+1]   = r_b_p;
      assign w_sgn_in[k+1] = r_sgn_p;
    end
  end

  assign out_valid = w_vld_out[STAGES-1];
  assign mul_out   = w_sum_out[STAGES-1];

  // busy covers every stage including the output register.
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      busy = busy | w_vld_out[k];
    end
  end

endmodule

// File: tb/tb_mul_pipe_hs.sv
// Bench for mul_pipe_hs: reference products from plain integer multiplication,
// in-order queue scoreboard, directed literals, random handshake traffic and a
// small parameter sweep running alongside the main instance.
module tb_mul_pipe_hs;

  localparam int W = 8;
  localparam int S = 2;

  typedef struct {
    longint p;
    int     cyc;
    int     stl;
    bit     shown;
  } item_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_signed;
  logic [W-1:0]     mul_a, mul_b;
  logic             out_valid, out_ready, busy;
  logic [2*W-1:0]   mul_out;
  logic             rst_x;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_pipe_hs #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .mul_a(mul_a), .mul_b(mul_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .mul_out(mul_out), .busy(busy)
  );

  // Exact product of w-bit operands, reduced to 2*w bits.
  function automatic longint ref_mul(input longint a, input longint b, input int w, input bit s);
    longint sa, sb, p;
    sa = a;
    sb = b;
    if (s) begin
      if (a >= (64'sd1 <<< (w - 1))) sa = a - (64'sd1 <<< w);
      if (b >= (64'sd1 <<< (w - 1))) sb = b - (64'sd1 <<< w);
    end
    p = sa * sb;
    return p & ((64'sd1 <<< (2 * w)) - 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- main-instance scoreboard ----------------
  item_t       q[$];
  int          cyc = 0;
  int          stalls = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_out;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mul_out", mul_out, 0);
      q.delete();
      prev_stall = 0;
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      chk("busy_vs_inflight", busy, q.size() != 0);
      if (prev_stall) begin
        chk("hold_out_valid", out_valid, 1);
        chk("hold_mul_out", mul_out, prev_out);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("stale_out_valid", out_valid, 0);
        end else begin
          chk("product", mul_out, q[0].p);
          if (!q[0].shown && q[0].stl == stalls) chk("latency", cyc - q[0].cyc, S);
          q[0].shown = 1;
          if (out_ready) void'(q.pop_front());
          else stalls++;
        end
      end
      if (in_valid && in_ready)
        q.push_back('{ref_mul(longint'(mul_a), longint'(mul_b), W, in_signed), cyc, stalls, 0});
      prev_stall = out_valid && !out_ready;
      prev_out   = mul_out;
    end
  end

  // ---------------- drivers ----------------
  int waits = 0;
  int nstall = 0;
  bit last_acc = 1;

  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    int n;
    bit acc;
    n = 0;
    in_valid = 1; mul_a = a; mul_b = b; in_signed = s;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", acc, 1);
    in_valid = 0;
    waits += n - 1;
  endtask

  task automatic rstep(input int pv, input int pr);
    if (!in_valid || last_acc) begin
      in_valid  = ($urandom_range(99) < pv);
      mul_a     = W'($urandom);
      mul_b     = W'($urandom);
      in_signed = 1'($urandom);
    end
    out_ready = ($urandom_range(99) < pr);
    @(negedge clk);
    last_acc = in_valid && in_ready;
    if (!in_ready) nstall++;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 0;
    out_ready = 1;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("drain_timeout", busy, 0);
    last_acc = 1;
  endtask

  // ---------------- parameter sweep instances ----------------
  for (genvar g = 0; g < 3; g++) begin : g_x
    localparam int WX  = (g == 0) ? 4 : 16;
    localparam int SX  = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    localparam int NOP = (g == 0) ? 512 : 2000;

    logic            iv, ir, isg, ov, ordy, bz;
    logic [WX-1:0]   a, b;
    logic [2*WX-1:0] o;
    bit              done = 0;

    mul_pipe_hs #(.WIDTH(WX), .STAGES(SX)) u_dut (
      .clk(clk), .rst(rst_x),
      .in_valid(iv), .in_ready(ir), .in_signed(isg),
      .mul_a(a), .mul_b(b),
      .out_valid(ov), .out_ready(ordy),
      .mul_out(o), .busy(bz)
    );

    initial begin
      item_t xq[$];
      int    idx, ncyc, xstl;
      bit    acc;
      idx = 0; ncyc = 0; xstl = 0; acc = 1;
      iv = 0; isg = 0; a = '0; b = '0; ordy = 1;
      @(negedge rst_x);
      @(posedge clk); #1;
      while ((idx < NOP || xq.size() != 0) && ncyc < 20000) begin
        if (!iv || acc) begin
          if (idx < NOP) begin
            iv = 1;
            if (g == 0) begin
              b = WX'(idx); a = WX'(idx >> 4); isg = 1'(idx >> 8);
            end else begin
              a = WX'($urandom); b = WX'($urandom); isg = 1'($urandom);
            end
            idx++;
          end else begin
            iv = 0;
          end
        end
        ordy = ($urandom_range(3) != 0);
        @(negedge clk);
        ncyc++;
        chk("x_busy", bz, xq.size() != 0);
        if (ov) begin
          if (xq.size() == 0) begin
            chk("x_stale_out_valid", ov, 0);
          end else begin
            chk("x_product", o, xq[0].p);
            if (!xq[0].shown && xq[0].stl == xstl) chk("x_latency", ncyc - xq[0].cyc, SX);
            xq[0].shown = 1;
            if (ordy) void'(xq.pop_front());
            else xstl++;
          end
        end
        acc = iv && ir;
        if (acc) xq.push_back('{ref_mul(longint'(a), longint'(b), WX, isg), ncyc, xstl, 0});
        @(posedge clk); #1;
      end
      if (ncyc >= 20000) chk("x_timeout", ncyc, 0);
      done = 1;
    end
  end

  initial begin
    rst_x = 0;
    #1 rst_x = 1;
    repeat (2) @(posedge clk);
    #1 rst_x = 0;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst = 0; in_valid = 0; in_signed = 0; mul_a = '0; mul_b = '0; out_ready = 1;
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("ready_after_rst", in_ready, 1);

    // reference model pinned to hand-computed products
    chk("model_u_ff_ff", ref_mul(255, 255, 8, 0), 64'hFE01);
    chk("model_u_0_200", ref_mul(0, 200, 8, 0), 64'h0000);
    chk("model_s_80_80", ref_mul(8'h80, 8'h80, 8, 1), 64'h4000);
    chk("model_s_ff_01", ref_mul(8'hFF, 8'h01, 8, 1), 64'hFFFF);
    chk("model_s_7f_80", ref_mul(8'h7F, 8'h80, 8, 1), 64'hC080);
    chk("model_u_ff_01", ref_mul(8'hFF, 8'h01, 8, 0), 64'h00FF);

    // directed literals straight on the DUT
    send_op(8'd255, 8'd255, 0);
    repeat (S) @(negedge clk);
    chk("lit_ff_ff_valid", out_valid, 1);
    chk("lit_ff_ff", mul_out, 16'hFE01);
    @(posedge clk); #1;
    send_op(8'd0, 8'd200, 0);
    repeat (S) @(negedge clk);
    chk("lit_0_200", mul_out, 16'h0000);
    @(posedge clk); #1;

    // mixed modes back-to-back
    send_op(8'h80, 8'h80, 1);
    send_op(8'hFF, 8'h01, 1);
    send_op(8'h7F, 8'h80, 1);
    send_op(8'h80, 8'h80, 0);
    send_op(8'hFF, 8'h01, 0);
    drain();

    // full throughput
    waits = 0;
    for (int i = 0; i < 16; i++) send_op(W'($urandom), W'($urandom), 1'($urandom));
    chk("tput_no_wait", waits, 0);
    drain();

    // backpressure on a full pipe
    nstall = 0;
    repeat (8) rstep(100, 0);
    chk("bp_stall_cycles", nstall, 6);
    chk("bp_in_ready_low", in_ready, 0);
    repeat (6) rstep(100, 100);
    drain();

    // random traffic with random backpressure
    repeat (300) rstep(70, 70);
    drain();

    // reset mid-flight
    send_op(8'd17, 8'd9, 0);
    send_op(8'hF3, 8'h21, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_mul_out", mul_out, 0);
    repeat (4) @(posedge clk);
    #1;
    send_op(8'd3, 8'd5, 0);
    repeat (S) @(negedge clk);
    chk("after_rst_valid", out_valid, 1);
    chk("after_rst_3x5", mul_out, 16'd15);
    @(posedge clk); #1;
    drain();

    n = 0;
    while (!(g_x[0].done && g_x[1].done && g_x[2].done) && n < 30000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 30000) chk("sweep_timeout", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
